// File: rtl/cond_pkg.sv
// Shared types and constants for the condition/flags stage.
package cond_pkg;

    // ARM-style condition field encodings
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAGS_W = 4;

    // Bit positions within {N,Z,C,V}, matching the ALU FLAGS ordering
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // flag_w encodings: bit 1 selects N,Z and bit 0 selects C,V
    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_CV   = 2'b01;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU side bundle into the condition stage and its gated results.
interface cond_logic_if;
    import cond_pkg::*;

    logic               en;
    logic [3:0]         cond;
    logic [FLAGS_W-1:0] alu_flags;
    logic [1:0]         flag_w;
    logic               pcs;
    logic               reg_w;
    logic               mem_w;
    logic               pc_src;
    logic               reg_write;
    logic               mem_write;
    logic               cond_ex;
    logic [FLAGS_W-1:0] flags;

    modport master (
        output en, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
        input  pc_src, reg_write, mem_write, cond_ex, flags
    );

    modport slave (
        input  en, cond, alu_flags, flag_w, pcs, reg_w, mem_w,
        output pc_src, reg_write, mem_write, cond_ex, flags
    );

endinterface

// File: rtl/cond_check.sv
// Combinational condition evaluator: cond field against a {N,Z,C,V} flags word.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_ex_c
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode every condition code; NV is treated as never
    always_comb begin
        cond_ex_c = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex_c = z;
            COND_NE: cond_ex_c = ~z;
            COND_CS: cond_ex_c = c;
            COND_CC: cond_ex_c = ~c;
            COND_MI: cond_ex_c = n;
            COND_PL: cond_ex_c = ~n;
            COND_VS: cond_ex_c = v;
            COND_VC: cond_ex_c = ~v;
            COND_HI: cond_ex_c = c & ~z;
            COND_LS: cond_ex_c = ~c | z;
            COND_GE: cond_ex_c = ~(n ^ v);
            COND_LT: cond_ex_c = n ^ v;
            COND_GT: cond_ex_c = ~z & ~(n ^ v);
            COND_LE: cond_ex_c = z | (n ^ v);
            COND_AL: cond_ex_c = 1'b1;
            COND_NV: cond_ex_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Architectural flags register plus condition-gated write enables.
// cond_ex always looks at the stored flags, so an instruction that both
// tests and sets flags sees the old values; the new ones appear next cycle.
module cond_logic
    import cond_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       cond_ex;
    logic       upd;

    cond_check u_cond_check (
        .cond      (bus.cond),
        .flags     ({nz_q, cv_q}),
        .cond_ex_c (cond_ex)
    );

    // Next flag halves: each half updates only on its own flag_w bit when enabled and passed
    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        upd  = bus.en & cond_ex;
        if (upd && bus.flag_w[1]) nz_d = bus.alu_flags[FLAG_N:FLAG_Z];
        if (upd && bus.flag_w[0]) cv_d = bus.alu_flags[FLAG_C:FLAG_V];
    end

    // Flags register; reset wins over any pending update
    always_ff @(posedge clk) begin
        if (reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    // Gated requests are not masked by en; stalls are handled downstream
    assign bus.cond_ex   = cond_ex;
    assign bus.pc_src    = bus.pcs   & cond_ex;
    assign bus.reg_write = bus.reg_w & cond_ex;
    assign bus.mem_write = bus.mem_w & cond_ex;
    assign bus.flags     = {nz_q, cv_q};

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios, full cond x flags sweep, random run.
module tb_cond_logic;

    logic clk;
    logic reset;

    cond_logic_if bus_if ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [3:0] m_flags;
    logic       m_valid;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    // Reference: even codes test a base predicate, odd codes its inverse; 14 always, 15 never
    function automatic logic ref_ex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic set_in(input logic rst, input logic en, input logic [3:0] cond,
                          input logic [3:0] af, input logic [1:0] fw,
                          input logic pcs, input logic rw, input logic mw);
        reset            = rst;
        bus_if.en        = en;
        bus_if.cond      = cond;
        bus_if.alu_flags = af;
        bus_if.flag_w    = fw;
        bus_if.pcs       = pcs;
        bus_if.reg_w     = rw;
        bus_if.mem_w     = mw;
    endtask

    // Check outputs against the model, then advance one edge and update the model
    task automatic tick();
        logic       ex;
        logic [3:0] nxt;
        #2;
        if (m_valid) begin
            ex = ref_ex(bus_if.cond, m_flags);
            chk("cond_ex",   {3'b0, bus_if.cond_ex},   {3'b0, ex});
            chk("pc_src",    {3'b0, bus_if.pc_src},    {3'b0, bus_if.pcs & ex});
            chk("reg_write", {3'b0, bus_if.reg_write}, {3'b0, bus_if.reg_w & ex});
            chk("mem_write", {3'b0, bus_if.mem_write}, {3'b0, bus_if.mem_w & ex});
            chk("flags",     bus_if.flags,             m_flags);
        end else begin
            ex = 1'b0;
        end
        nxt = m_flags;
        if (reset) begin
            nxt = 4'b0000;
        end else if (m_valid && bus_if.en && ex) begin
            if (bus_if.flag_w[1]) nxt[3:2] = bus_if.alu_flags[3:2];
            if (bus_if.flag_w[0]) nxt[1:0] = bus_if.alu_flags[1:0];
        end
        @(posedge clk);
        m_flags = nxt;
        if (reset) m_valid = 1'b1;
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        set_in(1'b0, 1'b1, 4'b1110, f, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic cond_const(input string tag, input logic [3:0] c, input logic exp);
        set_in(1'b0, 1'b1, c, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1);
        #1;
        chk(tag, {3'b0, bus_if.cond_ex}, {3'b0, exp});
        tick();
    endtask

    initial begin
        m_flags = 4'b0000;
        m_valid = 1'b0;

        // Reset, then EQ fails and AL passes on cleared flags
        set_in(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rst_flags", bus_if.flags, 4'b0000);
        chk("rst_eq_ex", {3'b0, bus_if.cond_ex}, 4'b0000);
        chk("rst_eq_rw", {3'b0, bus_if.reg_write}, 4'b0000);
        tick();
        set_in(1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
        #1;
        chk("rst_al_rw", {3'b0, bus_if.reg_write}, 4'b0001);
        tick();
        cond_const("rst_ne", 4'b0001, 1'b1);
        cond_const("rst_ge", 4'b1010, 1'b1);
        cond_const("rst_ls", 4'b1001, 1'b1);

        // Capture latency: flags change only after the edge
        set_in(1'b0, 1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cap_before", bus_if.flags, 4'b0000);
        tick();
        set_in(1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("cap_after", bus_if.flags, 4'b0100);
        chk("cap_eq_pc", {3'b0, bus_if.pc_src}, 4'b0001);
        tick();
        set_in(1'b0, 1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("cap_ne_pc", {3'b0, bus_if.pc_src}, 4'b0000);
        tick();

        // Partial update keeps C,V
        load_flags(4'b0110);
        set_in(1'b0, 1'b1, 4'b1110, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("partial_nz", bus_if.flags, 4'b1010);
        tick();

        // Failed condition suppresses all side effects
        load_flags(4'b0000);
        set_in(1'b0, 1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1);
        #1;
        chk("fail_pc",  {3'b0, bus_if.pc_src},    4'b0000);
        chk("fail_rw",  {3'b0, bus_if.reg_write}, 4'b0000);
        chk("fail_mw",  {3'b0, bus_if.mem_write}, 4'b0000);
        tick();
        set_in(1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("fail_flags", bus_if.flags, 4'b0000);
        tick();

        // Stall holds flags; reset beats a simultaneous enabled write
        load_flags(4'b0110);
        set_in(1'b0, 1'b0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0);
        #1;
        chk("stall_rw", {3'b0, bus_if.reg_write}, 4'b0001);
        tick();
        set_in(1'b1, 1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_hold", bus_if.flags, 4'b0110);
        tick();
        set_in(1'b0, 1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_prio", bus_if.flags, 4'b0000);
        tick();

        // Signed conditions
        load_flags(4'b1001);
        cond_const("ge_nv_eq", 4'b1010, 1'b1);
        cond_const("lt_nv_eq", 4'b1011, 1'b0);
        cond_const("gt_nv_eq", 4'b1100, 1'b1);
        cond_const("le_nv_eq", 4'b1101, 1'b0);
        load_flags(4'b1000);
        cond_const("ge_nv_ne", 4'b1010, 1'b0);
        cond_const("lt_nv_ne", 4'b1011, 1'b1);

        // Every condition code against every flag value
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                set_in(1'b0, 1'b1, 4'(c), 4'($urandom_range(0, 15)), 2'b00,
                       1'($urandom), 1'($urandom), 1'($urandom));
                tick();
            end
        end

        // Random instruction stream with occasional stalls and resets
        for (int i = 0; i < 600; i++) begin
            set_in(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
